rf_write_arbiter: RTL and testbench

Shares the single register-file write port between the in-order writeback stage and one long-latency unit (multiply/divide or load unit) that returns results out of pipeline order. Contains a one-entry holding buffer for the long-latency result, a per-register busy scoreboard that stalls decode on RAW/WAW hazards against outstanding results, and a starvation guard. Sits between writeback, the long-latency unit, decode, and the `register_file` write port (written on negedge `clk`).

---
 rtl/rf_write_arbiter.sv | 139 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: writeback has fixed priority, long-latency results
// go through a one-entry holding buffer, and a busy scoreboard stalls decode on hazards.
module rf_write_arbiter #(
   parameter int XLEN         = 32,
   parameter int NREGS        = 32,
   parameter int AW           = 5,
   parameter int STARVE_LIMIT = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            lu_valid,
   output logic            lu_ready,
   input  logic [AW-1:0]   lu_addr,
   input  logic [XLEN-1:0] lu_data,
   input  logic            iss_alloc,
   input  logic [AW-1:0]   iss_rd,
   input  logic            dec_valid,
   input  logic [AW-1:0]   dec_rs1,
   input  logic [AW-1:0]   dec_rs2,
   input  logic [AW-1:0]   dec_rd,
   output logic            dec_stall,
   output logic            rf_we,
   output logic [AW-1:0]   rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            sb_err
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

   logic            hold_valid;
   logic [AW-1:0]   hold_addr;
   logic [XLEN-1:0] hold_data;
   logic [NREGS-1:1] busy;
   logic [CW-1:0]   starve_cnt;
   logic            sb_err_q;

   logic [NREGS-1:0] busy_full;
   logic [NREGS-1:0] set_vec;
   logic [NREGS-1:0] clr_vec;
   logic [NREGS-1:0] busy_next;

   logic wb_eff;
   logic drain;
   logic accept;
   logic alloc_nz;
   logic starve;
   logic hazard;
   logic err_realloc;
   logic err_lu;
   logic err_wb;

   // x0 is folded in as a permanently idle bit so lookups need no special case
   assign busy_full = {busy, 1'b0};

   function automatic logic is_busy(input logic [AW-1:0] a);
      is_busy = (int'(a) < NREGS) ? busy_full[a] : 1'b0;
   endfunction

   assign wb_eff   = wb_valid && (wb_addr != '0);
   assign drain    = !wb_eff && hold_valid;
   assign lu_ready = rst_n && (!hold_valid || drain);
   assign accept   = lu_valid && lu_ready;
   assign alloc_nz = iss_alloc && (iss_rd != '0);
   assign starve   = (starve_cnt == LIMIT_C);

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (alloc_nz && (int'(iss_rd) < NREGS))
         set_vec[iss_rd] = 1'b1;
      if (drain && (int'(hold_addr) < NREGS))
         clr_vec[hold_addr] = 1'b1;
      clr_vec[0] = 1'b1;
      busy_next = (busy_full & ~clr_vec) | set_vec;
   end

   // A reallocation is legal only if the same register's old result drains this cycle
   always_comb begin
      err_realloc = alloc_nz && is_busy(iss_rd) && !(drain && (hold_addr == iss_rd));
      err_lu      = accept && !is_busy(lu_addr);
      err_wb      = wb_eff && is_busy(wb_addr);
   end

   always_comb begin
      hazard    = is_busy(dec_rs1) || is_busy(dec_rs2) || is_busy(dec_rd);
      dec_stall = rst_n && ((dec_valid && hazard) || starve);
   end

   // Writeback owns the port whenever it writes a real register; hold drains otherwise
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (rst_n) begin
         if (wb_eff) begin
            rf_we    = 1'b1;
            rf_waddr = wb_addr;
            rf_wdata = wb_data;
         end else if (hold_valid) begin
            rf_we    = 1'b1;
            rf_waddr = hold_addr;
            rf_wdata = hold_data;
         end
      end
   end

   assign sb_err = sb_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         hold_addr  <= '0;
         hold_data  <= '0;
         busy       <= '0;
         starve_cnt <= '0;
         sb_err_q   <= 1'b0;
      end else begin
         if (accept) begin
            hold_valid <= 1'b1;
            hold_addr  <= lu_addr;
            hold_data  <= lu_data;
         end else if (drain) begin
            hold_valid <= 1'b0;
         end
         busy <= busy_next[NREGS-1:1];
         if (drain)
            starve_cnt <= '0;
         else if (hold_valid && (starve_cnt != LIMIT_C))
            starve_cnt <= starve_cnt + 1'b1;
         if (err_realloc || err_lu || err_wb)
            sb_err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: register-file writes are checked by a scoreboard
// monitor, status outputs by direct comparisons against hand-computed values.
module tb_rf_write_arbiter;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   typedef struct packed {
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
   } wr_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            wb_valid;
   logic [AW-1:0]   wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            lu_valid;
   logic            lu_ready;
   logic [AW-1:0]   lu_addr;
   logic [XLEN-1:0] lu_data;
   logic            iss_alloc;
   logic [AW-1:0]   iss_rd;
   logic            dec_valid;
   logic [AW-1:0]   dec_rs1;
   logic [AW-1:0]   dec_rs2;
   logic [AW-1:0]   dec_rd;
   logic            dec_stall;
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic            sb_err;

   wr_t exp_q[$];
   wr_t mon_e;
   int  check_count = 0;
   int  pass_count  = 0;

   rf_write_arbiter #(.XLEN(XLEN), .NREGS(32), .AW(AW), .STARVE_LIMIT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
      .iss_alloc(iss_alloc), .iss_rd(iss_rd),
      .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
      .dec_stall(dec_stall),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual === expected)
         pass_count++;
      else
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic wbv, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                                input logic luv, input logic [AW-1:0] la, input logic [XLEN-1:0] ld,
                                input logic alloc, input logic [AW-1:0] rd);
      wb_valid  = wbv;
      wb_addr   = wa;
      wb_data   = wd;
      lu_valid  = luv;
      lu_addr   = la;
      lu_data   = ld;
      iss_alloc = alloc;
      iss_rd    = rd;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic setDecode(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                            input logic [AW-1:0] rd);
      dec_valid = v;
      dec_rs1   = r1;
      dec_rs2   = r2;
      dec_rd    = rd;
   endtask

   task automatic expectWrite(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      exp_q.push_back('{addr: a, data: d});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("reset_clears_sb_err", sb_err, 0);
      tick();
      rst_n = 1'b1;
   endtask

   // Every register-file write the DUT presents is matched against the next expected write
   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_count++;
            $display("[TB] FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                     rf_waddr, rf_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("rf_waddr", 32'(rf_waddr), 32'(mon_e.addr));
            checkOutput("rf_wdata", rf_wdata, mon_e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      setDecode(1, 7, 8, 9);
      @(negedge clk);
      checkOutput("rst_rf_we", rf_we, 0);
      checkOutput("rst_lu_ready", lu_ready, 0);
      checkOutput("rst_dec_stall", dec_stall, 0);
      checkOutput("rst_sb_err", sb_err, 0);
      checkOutput("rst_rf_waddr", 32'(rf_waddr), 0);
      tick();
      rst_n = 1'b1;
      setDecode(1, 1, 2, 3);
      @(negedge clk);
      checkOutput("idle_lu_ready", lu_ready, 1);
      checkOutput("idle_rf_we", rf_we, 0);
      checkOutput("idle_sb_err", sb_err, 0);
      for (int r = 1; r < 32; r++) begin
         tick();
         setDecode(1, AW'(r), AW'(r), AW'(r));
         @(negedge clk);
         checkOutput($sformatf("idle_stall_x%0d", r), dec_stall, 0);
      end

      // Combinational writeback, and writeback to x0 suppressed
      tick();
      setDecode(0, 0, 0, 0);
      applyStimulus(1, 5, 32'hA5A5_A5A5, 0, 0, 0, 0, 0);
      expectWrite(5, 32'hA5A5_A5A5);
      @(negedge clk);
      checkOutput("wb_x5_we", rf_we, 1);
      tick();
      applyStimulus(1, 0, 32'hA5A5_A5A5, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("wb_x0_we", rf_we, 0);

      // RAW hazard on x7 resolved by a long-latency return
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
      tick();
      idle();
      setDecode(1, 7, 0, 0);
      @(negedge clk);
      checkOutput("raw_x7_stall", dec_stall, 1);
      tick();
      applyStimulus(0, 0, 0, 1, 7, 32'h1234, 0, 0);
      expectWrite(7, 32'h1234);
      @(negedge clk);
      checkOutput("lu_x7_ready", lu_ready, 1);
      checkOutput("lu_no_passthrough", rf_we, 0);
      checkOutput("x7_stall_n", dec_stall, 1);
      tick();
      idle();
      @(negedge clk);
      checkOutput("x7_drain_we", rf_we, 1);
      checkOutput("x7_stall_n1", dec_stall, 1);
      tick();
      @(negedge clk);
      checkOutput("x7_stall_n2", dec_stall, 0);
      checkOutput("x7_sb_err", sb_err, 0);

      // Back-to-back results: drain and accept in one cycle, WB to x0 does not block
      tick();
      setDecode(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 11);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 12);
      tick();
      applyStimulus(0, 0, 0, 1, 11, 32'hB0B0, 0, 0);
      expectWrite(11, 32'hB0B0);
      tick();
      applyStimulus(1, 0, 32'hDEAD, 1, 12, 32'hC0C0, 0, 0);
      expectWrite(12, 32'hC0C0);
      @(negedge clk);
      checkOutput("b2b_lu_ready", lu_ready, 1);
      tick();
      idle();
      tick();
      setDecode(1, 11, 12, 0);
      @(negedge clk);
      checkOutput("b2b_busy_clear", dec_stall, 0);
      checkOutput("b2b_sb_err", sb_err, 0);

      // Starvation: x9 held while writeback owns the port every cycle
      tick();
      setDecode(1, 1, 2, 3);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
      tick();
      applyStimulus(1, 2, 32'h100, 1, 9, 32'h99, 0, 0);
      expectWrite(2, 32'h100);
      for (int i = 1; i <= 10; i++) begin
         tick();
         applyStimulus(1, 2, 32'h100 + 32'(i), 0, 0, 0, 0, 0);
         expectWrite(2, 32'h100 + 32'(i));
         @(negedge clk);
         checkOutput($sformatf("starve_lu_ready_%0d", i), lu_ready, 0);
         checkOutput($sformatf("starve_stall_%0d", i), dec_stall, (i >= 9) ? 1 : 0);
      end
      tick();
      idle();
      expectWrite(9, 32'h99);
      @(negedge clk);
      checkOutput("starve_drain_stall", dec_stall, 1);
      tick();
      @(negedge clk);
      checkOutput("starve_release", dec_stall, 0);
      checkOutput("starve_lu_ready_after", lu_ready, 1);

      // Protocol error: reallocating a busy register
      tick();
      setDecode(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3);
      @(negedge clk);
      checkOutput("realloc_before", sb_err, 0);
      tick();
      idle();
      @(negedge clk);
      checkOutput("err_realloc", sb_err, 1);
      tick();
      tick();
      @(negedge clk);
      checkOutput("err_sticky", sb_err, 1);
      doReset();

      // Protocol error: result for a register that was never allocated
      tick();
      applyStimulus(0, 0, 0, 1, 4, 32'h44, 0, 0);
      expectWrite(4, 32'h44);
      @(negedge clk);
      checkOutput("lu_nonbusy_before", sb_err, 0);
      tick();
      idle();
      @(negedge clk);
      checkOutput("err_lu_nonbusy", sb_err, 1);
      doReset();

      // Protocol error: writeback to a register with an outstanding result
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 6);
      tick();
      applyStimulus(1, 6, 32'h66, 0, 0, 0, 0, 0);
      expectWrite(6, 32'h66);
      tick();
      idle();
      @(negedge clk);
      checkOutput("err_wb_busy", sb_err, 1);
      doReset();

      // Asynchronous reset with a held result and x10 busy
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 10);
      tick();
      applyStimulus(0, 0, 0, 1, 10, 32'hAAAA, 0, 0);
      expectWrite(10, 32'hAAAA);
      tick();
      exp_q.pop_back();
      applyStimulus(1, 2, 32'h222, 0, 0, 0, 0, 0);
      setDecode(1, 10, 0, 0);
      #1;
      checkOutput("pre_reset_stall", dec_stall, 1);
      checkOutput("pre_reset_lu_ready", lu_ready, 0);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rf_we", rf_we, 0);
      checkOutput("async_lu_ready", lu_ready, 0);
      checkOutput("async_dec_stall", dec_stall, 0);
      checkOutput("async_rf_waddr", 32'(rf_waddr), 0);
      checkOutput("async_rf_wdata", rf_wdata, 0);
      checkOutput("async_sb_err", sb_err, 0);
      tick();
      rst_n = 1'b1;
      idle();
      setDecode(1, 10, 0, 0);
      @(negedge clk);
      checkOutput("post_reset_x10_free", dec_stall, 0);
      checkOutput("post_reset_lu_ready", lu_ready, 1);
      checkOutput("post_reset_no_write", rf_we, 0);
      tick();
      tick();
      checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
